// File: rtl/comb_lock.sv
// comb_lock: synchronous 4-digit BCD combination lock.
//   Each code_valid strobe compares in_code against SECRET. A match opens
//   the lock (status=1); MAX_FAIL consecutive mismatches enter lockout,
//   which ignores all attempts until reset.
//   Optional macro COMB_LOCK_TIMEOUT_EN: lockout self-clears after
//   LOCKOUT_CYCLES clocks (returns to READY, fail_cnt=0).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (highest priority)
//   code_valid in   one-cycle strobe qualifying in_code
//   in_code    in   attempted code, BCD, MS digit in top nibble
//   status     out  1 = unlocked (last accepted attempt matched)
//   locked_out out  1 = lockout active, attempts ignored
//   fail_cnt   out  consecutive-failure count, saturates at MAX_FAIL
module comb_lock #(
  parameter int                    NUM_DIGITS     = 4,
  parameter int                    CODE_W         = 4*NUM_DIGITS,
  parameter logic [CODE_W-1:0]     SECRET         = 16'h1473,
  parameter int                    MAX_FAIL       = 3,
  parameter int                    LOCKOUT_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             code_valid,
  input  logic [CODE_W-1:0]                in_code,
  output logic                             status,
  output logic                             locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);
  localparam int              FW    = $clog2(MAX_FAIL+1);
  localparam logic [FW-1:0]   MAX_F = FW'(MAX_FAIL);

  typedef enum logic [1:0] {READY, OPEN, LOCKOUT} state_t;

  state_t          state_q;
  logic [FW-1:0]   fail_q;
  logic            status_q;
  logic            locked_q;

  // Combinational helpers for the FSM
  logic            bcd_ok_d;
  logic            match_d;
  logic [FW-1:0]   fail_d;

`ifdef COMB_LOCK_TIMEOUT_EN
  localparam int            TW    = $clog2(LOCKOUT_CYCLES+1);
  localparam logic [TW-1:0] LOAD  = TW'(LOCKOUT_CYCLES);
  logic [TW-1:0]  tmr_q;
`endif

  // Any nibble above 9 is rejected outright, even if SECRET were
  // (mis)configured to contain one.
  always_comb begin
    bcd_ok_d = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (in_code[4*i +: 4] > 4'd9) bcd_ok_d = 1'b0;
    match_d = bcd_ok_d && (in_code == SECRET);
    // Only evaluated outside lockout, where fail_q < MAX_F, so no wrap.
    fail_d  = fail_q + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= READY;
      fail_q   <= '0;
      status_q <= 1'b0;
      locked_q <= 1'b0;
`ifdef COMB_LOCK_TIMEOUT_EN
      tmr_q    <= '0;
`endif
    end else begin
      case (state_q)
        READY, OPEN: begin
          if (code_valid) begin
            if (match_d) begin
              state_q  <= OPEN;
              status_q <= 1'b1;
              fail_q   <= '0;
            end else if (fail_d == MAX_F) begin
              state_q  <= LOCKOUT;
              status_q <= 1'b0;
              locked_q <= 1'b1;
              fail_q   <= MAX_F;
`ifdef COMB_LOCK_TIMEOUT_EN
              tmr_q    <= LOAD;
`endif
            end else begin
              // A mismatch while OPEN relocks immediately.
              state_q  <= READY;
              status_q <= 1'b0;
              fail_q   <= fail_d;
            end
          end
        end
        LOCKOUT: begin
`ifdef COMB_LOCK_TIMEOUT_EN
          // Exit on the LOCKOUT_CYCLES-th edge spent here; a strobe on
          // that edge is dropped because it is not evaluated in LOCKOUT.
          if (tmr_q <= TW'(1)) begin
            state_q  <= READY;
            locked_q <= 1'b0;
            fail_q   <= '0;
            tmr_q    <= '0;
          end else begin
            tmr_q    <= tmr_q - TW'(1);
          end
`endif
        end
        default: begin
          state_q  <= READY;
          status_q <= 1'b0;
          locked_q <= 1'b0;
          fail_q   <= '0;
        end
      endcase
    end
  end

  assign status     = status_q;
  assign locked_out = locked_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_comb_lock.sv
// tb_comb_lock: randomized self-checking bench for comb_lock (default build,
// lockout persists until reset). A behavioural model tracks an "open" flag,
// a "locked" flag and an integer failure count, updated per accepted attempt.
module tb_comb_lock;
  localparam int          MAX_FAIL = 3;
  localparam logic [15:0] SECRET   = 16'h1473;

  logic        clk = 1'b0;
  logic        reset;
  logic        code_valid;
  logic [15:0] in_code;
  logic        status;
  logic        locked_out;
  logic [1:0]  fail_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_open;
  bit m_lock;
  int m_fail;

  comb_lock #(.MAX_FAIL(MAX_FAIL), .SECRET(SECRET)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .in_code    (in_code),
    .status     (status),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_match(input logic [15:0] c);
    for (int i = 0; i < 4; i++)
      if (((c >> (4*i)) & 16'hF) > 9) return 1'b0;
    return c == SECRET;
  endfunction

  function automatic void model(input bit rst, input bit v, input logic [15:0] c);
    if (rst) begin
      m_open = 0; m_lock = 0; m_fail = 0;
    end else if (v && !m_lock) begin
      if (is_match(c)) begin
        m_open = 1; m_fail = 0;
      end else begin
        m_open = 0;
        m_fail = m_fail + 1;
        if (m_fail >= MAX_FAIL) begin
          m_fail = MAX_FAIL; m_lock = 1;
        end
      end
    end
  endfunction

  // Apply one cycle of inputs, advance the model, compare after the edge.
  task automatic step(input string tag, input bit rst, input bit v, input logic [15:0] c);
    reset = rst; code_valid = v; in_code = c;
    @(posedge clk);
    model(rst, v, c);
    #1;
    chk({tag, ".status"},     int'(status),     int'(m_open));
    chk({tag, ".locked_out"}, int'(locked_out), int'(m_lock));
    chk({tag, ".fail_cnt"},   int'(fail_cnt),   m_fail);
    reset = 0; code_valid = 0;
  endtask

  initial begin
    logic [15:0] c;
    logic [15:0] plan [6];
    reset = 1; code_valid = 0; in_code = '0;
    m_open = 0; m_lock = 0; m_fail = 0;
    @(negedge clk);

    // Reset state, including reset winning over a correct strobe.
    step("rst", 1, 1, SECRET);
    chk("rst_const.fail", int'(fail_cnt), 0);
    // Correct code opens.
    step("open", 0, 1, 16'h1473);
    chk("open_const.status", int'(status), 1);
    // Idle cycles hold OPEN; in_code changes without strobe do nothing.
    step("idle0", 0, 0, 16'h9999);
    step("idle1", 0, 0, 16'h0000);
    // Mismatch in OPEN relocks.
    step("relock", 0, 1, 16'h2189);
    chk("relock_const.fail", int'(fail_cnt), 1);
    // Three failures into lockout.
    step("rst2", 1, 0, 16'h0);
    step("f1", 0, 1, 16'h1273);
    step("f2", 0, 1, 16'h1483);
    step("f3", 0, 1, 16'h2473);
    chk("lock_const.locked", int'(locked_out), 1);
    // Lockout ignores wrong and correct codes (back-to-back).
    step("lk_bad", 0, 1, 16'h4667);
    step("lk_good", 0, 1, SECRET);
    for (int i = 0; i < 20; i++) step("lk_hold", 0, 0, 16'h0);
    chk("lock_const.fail", int'(fail_cnt), 3);
    // Reset pulse clears lockout, then open.
    step("rst3", 1, 0, 16'h0);
    step("reopen", 0, 1, SECRET);
    // Sequence with invalid BCD nibble counting as failure.
    step("rst4", 1, 0, 16'h0);
    plan = '{16'h1273, 16'h1283, 16'h1473, 16'h1A73, 16'h147A, 16'hFFFF};
    for (int i = 0; i < 4; i++) step("seq", 0, 1, plan[i]);
    chk("seq_const.fail", int'(fail_cnt), 1);
    // Invalid-digit codes push into lockout.
    step("inv1", 0, 1, plan[4]);
    step("inv2", 0, 1, plan[5]);

    // Randomized phase.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 40)      c = SECRET;
      else if (r < 65) c = SECRET ^ (16'(($urandom_range(1, 15))) << (4*$urandom_range(0, 3)));
      else             c = 16'($urandom);
      step("rnd", ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 70), c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
